// File: rtl/rmii_tx_framer_pkg.sv
// Shared RMII TX definitions: line symbols, field lengths, FSM encoding and the dibit CRC step.
// Combinational helpers only; nothing here holds state or applies backpressure.
package rmii_tx_framer_pkg;

    localparam logic [1:0]  PREAMBLE_DIBIT  = 2'b01;
    localparam logic [1:0]  SFD_LAST_DIBIT  = 2'b11;
    localparam int          PREAMBLE_DIBITS = 32;
    localparam int          FCS_DIBITS      = 16;
    localparam logic [31:0] CRC_INIT        = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC_POLY_REFL   = 32'hEDB8_8320;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_PREAMBLE = 3'd1,
        ST_PAYLOAD  = 3'd2,
        ST_PAD      = 3'd3,
        ST_FCS      = 3'd4,
        ST_IFG      = 3'd5
    } tx_state_t;

    // Reflected CRC-32 advanced by one dibit, bit 0 first (wire order).
    function automatic logic [31:0] crc32_dibit(input logic [31:0] crc, input logic [1:0] dibit);
        logic [31:0] c;
        c = crc;
        for (int i = 0; i < 2; i++) begin
            if (c[0] ^ dibit[i]) c = (c >> 1) ^ CRC_POLY_REFL;
            else                 c = c >> 1;
        end
        return c;
    endfunction

endpackage

// File: rtl/rmii_tx_framer_crc32.sv
// Ethernet FCS accumulator, one dibit per clk; fcs_out reflects all dibits up to the previous edge.
// Latency 1 clk; no backpressure, fcs_en low reloads the seed for the next frame.
module rmii_tx_framer_crc32
    import rmii_tx_framer_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        fcs_en,
    input  logic [1:0]  data,
    output logic [31:0] fcs_out
);

    logic [31:0] crc;

    always_ff @(posedge clk) begin
        if (rst || !fcs_en) crc <= CRC_INIT;
        else                crc <= crc32_dibit(crc, data);
    end

    assign fcs_out = ~crc;

endmodule

// File: rtl/rmii_tx_framer.sv
// RMII 100M TX framer: preamble/SFD, payload, zero pad, FCS, IFG from a valid/ready byte stream.
// Latency 1 clk from trigger to txen; tx_ready only once per 4 dibits, a missing byte aborts the frame.
module rmii_tx_framer
    import rmii_tx_framer_pkg::*;
#(
    parameter int MIN_PAYLOAD = 60,
    parameter int IFG_BYTES   = 12
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    input  logic       tx_last,
    output logic       tx_ready,
    output logic [1:0] rmii_txd,
    output logic       rmii_txen,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx_underrun
);

    localparam logic [10:0] MIN_CNT  = 11'(MIN_PAYLOAD);
    localparam int          IFG_CLKS = IFG_BYTES * 4;
    localparam logic [10:0] IFG_LAST = (IFG_CLKS > 0) ? 11'(IFG_CLKS - 1) : 11'd0;
    localparam logic [4:0]  PRE_LAST = 5'(PREAMBLE_DIBITS - 1);
    localparam logic [4:0]  FCS_LAST = 5'(FCS_DIBITS - 1);

    tx_state_t   state;
    logic [4:0]  dibit_cnt;
    logic [10:0] byte_cnt;
    logic [10:0] byte_inc;
    logic [7:0]  data_sr;
    logic [31:0] fcs_sr;
    logic        cur_last;
    logic [31:0] fcs_out;
    logic        crc_en;
    logic [1:0]  crc_data;
    logic        byte_end;
    logic        pad_more;
    logic        load_byte;
    logic        underrun;

    // crc_en/crc_data are exactly the enable and value of the next payload/pad txd load,
    // so the CRC engine and the wire never drift apart.
    always_comb begin
        byte_end  = (dibit_cnt == 5'd3);
        pad_more  = (byte_cnt < MIN_CNT);
        byte_inc  = (byte_cnt == 11'h7FF) ? byte_cnt : byte_cnt + 11'd1;
        tx_ready  = ((state == ST_PREAMBLE) && (dibit_cnt == PRE_LAST)) ||
                    ((state == ST_PAYLOAD) && byte_end && !cur_last);
        load_byte = tx_ready && tx_valid;
        underrun  = tx_ready && !tx_valid;
        crc_data  = load_byte ? tx_data[1:0] : data_sr[1:0];
        crc_en    = 1'b0;
        if (!rst) begin
            if (load_byte)
                crc_en = 1'b1;
            else if ((state == ST_PAYLOAD) || (state == ST_PAD))
                crc_en = !byte_end || (((state == ST_PAD) || cur_last) && pad_more);
        end
    end

    assign tx_busy = (state != ST_IDLE);

    rmii_tx_framer_crc32 u_crc (
        .clk     (clk),
        .rst     (rst),
        .fcs_en  (crc_en),
        .data    (crc_data),
        .fcs_out (fcs_out)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            dibit_cnt   <= 5'd0;
            byte_cnt    <= 11'd0;
            data_sr     <= 8'd0;
            fcs_sr      <= 32'd0;
            cur_last    <= 1'b0;
            rmii_txd    <= 2'b00;
            rmii_txen   <= 1'b0;
            tx_done     <= 1'b0;
            tx_underrun <= 1'b0;
        end else begin
            tx_done     <= 1'b0;
            tx_underrun <= 1'b0;
            if (underrun) begin
                state       <= ST_IFG;
                dibit_cnt   <= 5'd0;
                byte_cnt    <= 11'd0;
                rmii_txd    <= 2'b00;
                rmii_txen   <= 1'b0;
                tx_underrun <= 1'b1;
            end else if (load_byte) begin
                state     <= ST_PAYLOAD;
                dibit_cnt <= 5'd0;
                rmii_txd  <= crc_data;
                data_sr   <= {2'b00, tx_data[7:2]};
                cur_last  <= tx_last;
                byte_cnt  <= (state == ST_PREAMBLE) ? 11'd1 : byte_inc;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (tx_valid) begin
                            state     <= ST_PREAMBLE;
                            dibit_cnt <= 5'd0;
                            rmii_txd  <= PREAMBLE_DIBIT;
                            rmii_txen <= 1'b1;
                        end
                    end
                    ST_PREAMBLE: begin
                        dibit_cnt <= dibit_cnt + 5'd1;
                        rmii_txd  <= (dibit_cnt == PRE_LAST - 5'd1) ? SFD_LAST_DIBIT : PREAMBLE_DIBIT;
                    end
                    ST_PAYLOAD, ST_PAD: begin
                        if (crc_en) begin
                            rmii_txd <= crc_data;
                            data_sr  <= data_sr >> 2;
                            if (byte_end) begin
                                state     <= ST_PAD;
                                dibit_cnt <= 5'd0;
                                byte_cnt  <= byte_inc;
                            end else begin
                                dibit_cnt <= dibit_cnt + 5'd1;
                            end
                        end else begin
                            state     <= ST_FCS;
                            dibit_cnt <= 5'd0;
                            rmii_txd  <= fcs_out[1:0];
                            fcs_sr    <= {2'b00, fcs_out[31:2]};
                        end
                    end
                    ST_FCS: begin
                        if (dibit_cnt != FCS_LAST) begin
                            rmii_txd  <= fcs_sr[1:0];
                            fcs_sr    <= fcs_sr >> 2;
                            dibit_cnt <= dibit_cnt + 5'd1;
                            tx_done   <= (dibit_cnt == FCS_LAST - 5'd1);
                        end else begin
                            state     <= ST_IFG;
                            dibit_cnt <= 5'd0;
                            byte_cnt  <= 11'd0;
                            rmii_txd  <= 2'b00;
                            rmii_txen <= 1'b0;
                        end
                    end
                    // byte_cnt doubles as the gap timer while the line is idle
                    ST_IFG: begin
                        if (byte_cnt >= IFG_LAST) begin
                            if (tx_valid) begin
                                state     <= ST_PREAMBLE;
                                dibit_cnt <= 5'd0;
                                rmii_txd  <= PREAMBLE_DIBIT;
                                rmii_txen <= 1'b1;
                            end else begin
                                state <= ST_IDLE;
                            end
                        end else begin
                            byte_cnt <= byte_cnt + 11'd1;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_rmii_tx_framer.sv
// Bench for rmii_tx_framer: three instances (MIN_PAYLOAD 0/60/1) checked against a byte-level frame model.
module tb_rmii_tx_framer;

    logic clk = 1'b0;
    always #10 clk = ~clk;

    logic       rst;
    logic [7:0] tx_data     [3];
    logic       tx_valid    [3];
    logic       tx_last     [3];
    logic       tx_ready    [3];
    logic [1:0] rmii_txd    [3];
    logic       rmii_txen   [3];
    logic       tx_busy     [3];
    logic       tx_done     [3];
    logic       tx_underrun [3];

    rmii_tx_framer #(.MIN_PAYLOAD(0), .IFG_BYTES(12)) u_dut0 (
        .clk(clk), .rst(rst), .tx_data(tx_data[0]), .tx_valid(tx_valid[0]), .tx_last(tx_last[0]),
        .tx_ready(tx_ready[0]), .rmii_txd(rmii_txd[0]), .rmii_txen(rmii_txen[0]),
        .tx_busy(tx_busy[0]), .tx_done(tx_done[0]), .tx_underrun(tx_underrun[0]));
    rmii_tx_framer #(.MIN_PAYLOAD(60), .IFG_BYTES(12)) u_dut1 (
        .clk(clk), .rst(rst), .tx_data(tx_data[1]), .tx_valid(tx_valid[1]), .tx_last(tx_last[1]),
        .tx_ready(tx_ready[1]), .rmii_txd(rmii_txd[1]), .rmii_txen(rmii_txen[1]),
        .tx_busy(tx_busy[1]), .tx_done(tx_done[1]), .tx_underrun(tx_underrun[1]));
    rmii_tx_framer #(.MIN_PAYLOAD(1), .IFG_BYTES(12)) u_dut2 (
        .clk(clk), .rst(rst), .tx_data(tx_data[2]), .tx_valid(tx_valid[2]), .tx_last(tx_last[2]),
        .tx_ready(tx_ready[2]), .rmii_txd(rmii_txd[2]), .rmii_txen(rmii_txen[2]),
        .tx_busy(tx_busy[2]), .tx_done(tx_done[2]), .tx_underrun(tx_underrun[2]));

    int errors = 0;
    int checks = 0;

    logic [7:0] pay_q [$];
    bit         last_q[$];
    logic [1:0] exp_q [$];
    logic [1:0] cap_q [$];
    int         gap_q [$];
    int         done_cnt, under_cnt, done_pos, tail_low;
    logic       under_txen;
    bit         drv_ok, cap_ok;

    task automatic add_frame(input int n);
        for (int i = 0; i < n; i++) begin
            pay_q.push_back(8'($urandom));
            last_q.push_back(i == n - 1);
        end
    endtask

    // Reference: bytes on the wire = 7x55, D5, payload, zero pad, CRC-32 (LSB first); 4 dibits per byte.
    task automatic model_frame(input int first, input int count, input int min_pay);
        logic [7:0]  b[$];
        logic [31:0] crc;
        logic [7:0]  x;
        for (int i = 0; i < 7; i++) b.push_back(8'h55);
        b.push_back(8'hD5);
        crc = 32'hFFFF_FFFF;
        for (int i = 0; (i < count) || (i < min_pay); i++) begin
            x = (i < count) ? pay_q[first + i] : 8'h00;
            b.push_back(x);
            for (int k = 0; k < 8; k++)
                crc = (crc[0] ^ x[k]) ? ((crc >> 1) ^ 32'hEDB8_8320) : (crc >> 1);
        end
        crc = ~crc;
        for (int k = 0; k < 4; k++) b.push_back(crc[8*k +: 8]);
        foreach (b[j])
            for (int k = 0; k < 4; k++) exp_q.push_back(b[j][2*k +: 2]);
    endtask

    task automatic drive(input int sel, input int n_send);
        int guard;
        drv_ok = 1'b1;
        for (int i = 0; i < n_send; i++) begin
            tx_data[sel]  = pay_q[i];
            tx_last[sel]  = last_q[i];
            tx_valid[sel] = 1'b1;
            guard = 0;
            @(negedge clk);
            while (tx_ready[sel] !== 1'b1 && guard < 4000) begin
                @(negedge clk);
                guard++;
            end
            if (guard >= 4000) begin
                drv_ok = 1'b0;
                break;
            end
            @(posedge clk);
            #1;
        end
        tx_valid[sel] = 1'b0;
        tx_last[sel]  = 1'b0;
    endtask

    task automatic capture(input int sel);
        bit started;
        int low_run;
        cap_q.delete();
        gap_q.delete();
        done_cnt = 0; under_cnt = 0; done_pos = -1; tail_low = 0; under_txen = 1'b1;
        started = 1'b0; low_run = 0; cap_ok = 1'b0;
        for (int g = 0; g < 20000; g++) begin
            @(negedge clk);
            if (tx_busy[sel]) started = 1'b1;
            else if (started) begin
                cap_ok = 1'b1;
                break;
            end
            if (rmii_txen[sel]) begin
                if (cap_q.size() > 0 && low_run > 0) gap_q.push_back(low_run);
                low_run = 0;
                cap_q.push_back(rmii_txd[sel]);
            end else if (cap_q.size() > 0) begin
                low_run++;
            end
            if (tx_done[sel]) begin
                done_cnt++;
                done_pos = cap_q.size();
            end
            if (tx_underrun[sel]) begin
                under_cnt++;
                under_txen = rmii_txen[sel];
            end
        end
        tail_low = low_run;
    endtask

    task automatic run_frames(input int sel, input int n_send);
        @(posedge clk);
        #1;
        fork
            drive(sel, n_send);
            capture(sel);
        join
    endtask

    function automatic int first_diff();
        int n;
        n = (cap_q.size() < exp_q.size()) ? cap_q.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            if (cap_q[i] !== exp_q[i]) return i;
        if (cap_q.size() != exp_q.size()) return n;
        return -1;
    endfunction

    task automatic new_frames();
        pay_q.delete();
        last_q.delete();
        exp_q.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int s = 0; s < 3; s++) begin
            checks++;
            if ({rmii_txd[s], rmii_txen[s]} !== 3'b000) begin
                errors++; $display("FAIL reset_line dut%0d got txd=%b txen=%b exp 00/0", s, rmii_txd[s], rmii_txen[s]);
            end
            checks++;
            if ({tx_ready[s], tx_busy[s], tx_done[s], tx_underrun[s]} !== 4'b0000) begin
                errors++; $display("FAIL reset_status dut%0d got rdy/busy/done/urun=%b%b%b%b exp 0000",
                                   s, tx_ready[s], tx_busy[s], tx_done[s], tx_underrun[s]);
            end
        end
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_check_value();
        logic [31:0] got_fcs;
        int d;
        new_frames();
        for (int i = 0; i < 9; i++) begin
            pay_q.push_back(8'h31 + 8'(i));
            last_q.push_back(i == 8);
        end
        model_frame(0, 9, 0);
        run_frames(0, 9);
        got_fcs = 32'hx;
        if (cap_q.size() >= 84)
            for (int k = 0; k < 16; k++) got_fcs[2*k +: 2] = cap_q[68 + k];
        d = first_diff();
        checks++;
        if (!(drv_ok && cap_ok)) begin errors++; $display("FAIL chk_timeout got drv=%0d cap=%0d exp 1/1", drv_ok, cap_ok); end
        checks++;
        if (cap_q.size() !== 84) begin errors++; $display("FAIL chk_txen_clks got %0d exp 84", cap_q.size()); end
        checks++;
        if (d !== -1) begin errors++; $display("FAIL chk_stream first bad dibit at %0d exp none", d); end
        checks++;
        if (got_fcs !== 32'hCBF4_3926) begin errors++; $display("FAIL chk_fcs got %h exp cbf43926", got_fcs); end
        checks++;
        if (got_fcs[1:0] !== 2'b10) begin errors++; $display("FAIL chk_fcs_first_dibit got %b exp 10", got_fcs[1:0]); end
        checks++;
        if (done_cnt !== 1 || done_pos !== 84) begin
            errors++; $display("FAIL chk_done got cnt=%0d pos=%0d exp 1/84", done_cnt, done_pos);
        end
        checks++;
        if (tail_low !== 48) begin errors++; $display("FAIL chk_ifg got %0d exp 48", tail_low); end
    endtask

    task automatic test_pad_min();
        int d;
        new_frames();
        pay_q.push_back(8'hAB);
        last_q.push_back(1'b1);
        model_frame(0, 1, 60);
        run_frames(1, 1);
        d = first_diff();
        checks++;
        if (cap_q.size() !== 288) begin errors++; $display("FAIL pad_txen_clks got %0d exp 288", cap_q.size()); end
        checks++;
        if (d !== -1) begin errors++; $display("FAIL pad_stream first bad dibit at %0d exp none", d); end
        checks++;
        if (done_pos !== 288) begin errors++; $display("FAIL pad_done_pos got %0d exp 288", done_pos); end
    endtask

    task automatic test_min_one();
        int d;
        new_frames();
        add_frame(1);
        model_frame(0, 1, 1);
        run_frames(2, 1);
        d = first_diff();
        checks++;
        if (cap_q.size() !== 52) begin errors++; $display("FAIL min1_txen_clks got %0d exp 52", cap_q.size()); end
        checks++;
        if (d !== -1) begin errors++; $display("FAIL min1_stream first bad dibit at %0d exp none", d); end
    endtask

    task automatic test_back_to_back();
        int d;
        new_frames();
        add_frame(64);
        add_frame(64);
        model_frame(0, 64, 60);
        model_frame(64, 64, 60);
        run_frames(1, 128);
        d = first_diff();
        checks++;
        if (cap_q.size() !== 608) begin errors++; $display("FAIL b2b_txen_clks got %0d exp 608", cap_q.size()); end
        checks++;
        if (d !== -1) begin errors++; $display("FAIL b2b_stream first bad dibit at %0d exp none", d); end
        checks++;
        if (gap_q.size() !== 1 || (gap_q.size() == 1 && gap_q[0] !== 48)) begin
            errors++; $display("FAIL b2b_gap got %0d gaps first=%0d exp 1 gap of 48",
                               gap_q.size(), (gap_q.size() > 0) ? gap_q[0] : -1);
        end
        checks++;
        if (done_cnt !== 2) begin errors++; $display("FAIL b2b_done got %0d exp 2", done_cnt); end
    endtask

    task automatic test_underrun();
        int d;
        new_frames();
        add_frame(64);
        model_frame(0, 10, 0);
        while (exp_q.size() > 72) void'(exp_q.pop_back());
        run_frames(1, 10);
        d = first_diff();
        checks++;
        if (under_cnt !== 1 || under_txen !== 1'b0) begin
            errors++; $display("FAIL urun_pulse got cnt=%0d txen=%b exp 1/0", under_cnt, under_txen);
        end
        checks++;
        if (cap_q.size() !== 72) begin errors++; $display("FAIL urun_txen_clks got %0d exp 72", cap_q.size()); end
        checks++;
        if (d !== -1) begin errors++; $display("FAIL urun_stream first bad dibit at %0d exp none", d); end
        checks++;
        if (done_cnt !== 0) begin errors++; $display("FAIL urun_no_done got %0d exp 0", done_cnt); end
        checks++;
        if (tail_low !== 48) begin errors++; $display("FAIL urun_ifg got %0d exp 48", tail_low); end
    endtask

    task automatic test_reset_midframe();
        int k, n, d;
        new_frames();
        add_frame(64);
        k = $urandom_range(3, 20);
        @(posedge clk);
        #1;
        drive(1, k);
        checks++;
        if (rmii_txen[1] !== 1'b1 || !drv_ok) begin
            errors++; $display("FAIL rstmid_pre got txen=%b drv=%0d exp 1/1", rmii_txen[1], drv_ok);
        end
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if ({rmii_txd[1], rmii_txen[1], tx_ready[1], tx_busy[1], tx_done[1], tx_underrun[1]} !== 7'd0) begin
            errors++; $display("FAIL rstmid_outputs got txd=%b txen=%b rdy=%b busy=%b done=%b urun=%b exp all 0",
                               rmii_txd[1], rmii_txen[1], tx_ready[1], tx_busy[1], tx_done[1], tx_underrun[1]);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        new_frames();
        n = $urandom_range(1, 70);
        add_frame(n);
        model_frame(0, n, 60);
        run_frames(1, n);
        d = first_diff();
        checks++;
        if (d !== -1) begin errors++; $display("FAIL rstmid_next_frame len %0d first bad dibit at %0d exp none", n, d); end
    endtask

    task automatic test_random_frames();
        int n, d, mp;
        for (int s = 0; s < 3; s++) begin
            mp = (s == 0) ? 0 : ((s == 1) ? 60 : 1);
            for (int f = 0; f < 2; f++) begin
                new_frames();
                n = $urandom_range(1, 80);
                add_frame(n);
                model_frame(0, n, mp);
                run_frames(s, n);
                d = first_diff();
                checks++;
                if (d !== -1 || done_cnt !== 1) begin
                    errors++; $display("FAIL rand_dut%0d_len%0d first bad dibit %0d done=%0d exp none/1", s, n, d, done_cnt);
                end
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        for (int s = 0; s < 3; s++) begin
            tx_data[s]  = 8'h00;
            tx_valid[s] = 1'b0;
            tx_last[s]  = 1'b0;
        end
        test_reset();
        test_check_value();
        test_pad_min();
        test_min_one();
        test_back_to_back();
        test_underrun();
        test_reset_midframe();
        test_random_frames();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
